// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals shared between the issuer and its environment.
// master is the issuer side; slave is the command source / ALU / response consumer side.
interface alu_cmd_issuer_if #(
  parameter int unsigned TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op;
  logic [8:0]       alu_result;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [8:0]       rsp_result;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, alu_overflow, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_overflow, rsp_tag,
           rsp_illegal
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, alu_overflow, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_overflow, rsp_tag,
           rsp_illegal
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers tagged ALU commands, issues them to a one-cycle-latency ALU and returns tagged
// responses through a 2-entry queue; issue is throttled so the queue can never overflow.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_cmd_issuer_if.master        bus,
  output logic [$clog2(DEPTH):0]  cmd_count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [8:0]       result;
    logic             overflow;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } rsp_t;

  cmd_t            fifo_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  cmd_t            head;
  logic            full, empty, push, issue;

  rsp_t            resp_q [2];
  logic            resp_wr_q, resp_rd_q;
  logic [1:0]      resp_count_q;
  logic            rsp_pop;
  logic [2:0]      credit;

  logic             inflight_q;
  logic [TAG_W-1:0] side_tag_q;
  logic             side_illegal_q;

  assign full          = (count_q == CntW'(DEPTH));
  assign empty         = (count_q == '0);
  assign bus.cmd_ready = !full && !rst;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = fifo_q[rd_ptr_q];
  assign cmd_count     = count_q;

  assign bus.rsp_valid = (resp_count_q != 2'd0) && !rst;
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

  // Queued responses plus the one in flight, less the one leaving now, must leave a free slot.
  assign credit = {1'b0, resp_count_q} + {2'b00, inflight_q} - {2'b00, rsp_pop};
  assign issue  = !empty && !rst && (credit < 3'd2);

  always_comb begin
    bus.alu_a  = 8'd0;
    bus.alu_b  = 8'd0;
    bus.alu_op = 3'b111;
    if (issue) begin
      bus.alu_a  = head.a;
      bus.alu_b  = head.b;
      bus.alu_op = head.op;
    end
  end

  always_comb begin
    bus.rsp_result   = 9'd0;
    bus.rsp_overflow = 1'b0;
    bus.rsp_tag      = '0;
    bus.rsp_illegal  = 1'b0;
    if (bus.rsp_valid) begin
      bus.rsp_result   = resp_q[resp_rd_q].result;
      bus.rsp_overflow = resp_q[resp_rd_q].overflow;
      bus.rsp_tag      = resp_q[resp_rd_q].tag;
      bus.rsp_illegal  = resp_q[resp_rd_q].illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, issue})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      side_tag_q     <= '0;
      side_illegal_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        side_tag_q     <= head.tag;
        side_illegal_q <= (head.op >= 3'd5);
      end
    end
  end

  // The ALU result is only meaningful the cycle after an issue, hence capture on inflight_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_wr_q    <= 1'b0;
      resp_rd_q    <= 1'b0;
      resp_count_q <= 2'd0;
    end else begin
      if (inflight_q) begin
        resp_q[resp_wr_q] <= {bus.alu_result, bus.alu_overflow, side_tag_q, side_illegal_q};
        resp_wr_q         <= ~resp_wr_q;
      end
      if (rsp_pop) resp_rd_q <= ~resp_rd_q;
      case ({inflight_q, rsp_pop})
        2'b10:   resp_count_q <= resp_count_q + 2'd1;
        2'b01:   resp_count_q <= resp_count_q - 2'd1;
        default: resp_count_q <= resp_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (resp_count_q <= 2'd2);
      assert (!(inflight_q && (resp_count_q == 2'd2) && !rsp_pop));
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a stand-in registered ALU, a queue-level reference model checked
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_alu_cmd_issuer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [8:0]       res;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(DEPTH):0] cmd_count;

  alu_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stand-in ALU: add flags signed overflow, sub flags borrow, ops 5..7 produce 0.
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [8:0] r;
    logic       o;
    r = 9'd0;
    o = 1'b0;
    case (op)
      3'd0: begin r = {1'b0, a} + {1'b0, b}; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = {1'b0, a} - {1'b0, b}; o = (a < b); end
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      default: ;
    endcase
    return {o, r};
  endfunction

  always @(posedge clk) {bus.alu_overflow, bus.alu_result} <= alu_ref(bus.alu_a, bus.alu_b,
                                                                       bus.alu_op);

  // Reference model: commands waiting, one in flight, responses queued, and a log of pops.
  cmd_t m_fifo[$];
  rsp_t m_resp[$];
  rsp_t m_infl;
  bit   m_infl_v = 1'b0;
  rsp_t log_q[$];
  int   log_cyc[$];
  bit   armed = 1'b0;

  always @(posedge clk) if (rst) armed <= 1'b1;

  always @(negedge clk) begin
    bit         er, ev, pop, iss;
    cmd_t       h, c;
    logic [9:0] r;
    if (armed) begin
      er = !rst && (m_fifo.size() < DEPTH);
      ev = !rst && (m_resp.size() != 0);
      check("cmd_ready", bus.cmd_ready, er);
      check("cmd_count", cmd_count, m_fifo.size());
      check("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        check("rsp_result", bus.rsp_result, m_resp[0].res);
        check("rsp_overflow", bus.rsp_overflow, m_resp[0].ovf);
        check("rsp_tag", bus.rsp_tag, m_resp[0].tag);
        check("rsp_illegal", bus.rsp_illegal, m_resp[0].ill);
      end else if (rst) begin
        check("rst_rsp_fields", {bus.rsp_result, bus.rsp_overflow, bus.rsp_tag, bus.rsp_illegal},
              0);
      end
      pop = ev && bus.rsp_ready;
      iss = !rst && (m_fifo.size() != 0) &&
            (m_resp.size() + int'(m_infl_v) - int'(pop) < 2);
      if (!rst) begin
        if (iss) begin
          check("alu_drive", {bus.alu_a, bus.alu_b, bus.alu_op},
                {m_fifo[0].a, m_fifo[0].b, m_fifo[0].op});
        end else begin
          check("alu_idle", {bus.alu_a, bus.alu_b, bus.alu_op}, {8'd0, 8'd0, 3'b111});
        end
      end
      if (rst) begin
        m_fifo.delete();
        m_resp.delete();
        m_infl_v = 1'b0;
      end else begin
        if (pop) begin
          log_q.push_back(m_resp[0]);
          log_cyc.push_back(cyc);
          void'(m_resp.pop_front());
        end
        if (m_infl_v) m_resp.push_back(m_infl);
        m_infl_v = iss;
        if (iss) begin
          h          = m_fifo.pop_front();
          r          = alu_ref(h.a, h.b, h.op);
          m_infl.res = r[8:0];
          m_infl.ovf = r[9];
          m_infl.tag = h.tag;
          m_infl.ill = (h.op >= 3'd5);
        end
        if (bus.cmd_valid && er) begin
          c.a   = bus.cmd_a;
          c.b   = bus.cmd_b;
          c.op  = bus.cmd_op;
          c.tag = bus.cmd_tag;
          m_fifo.push_back(c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag);
    bit acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      tick();
    end
    check("send_accept", acc, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int i;
    i = 0;
    while ((m_fifo.size() != 0 || m_resp.size() != 0 || m_infl_v) && i < max_cyc) begin
      tick();
      i++;
    end
    check("drain_in_time", (i < max_cyc), 1);
  endtask

  logic [7:0] va  [8] = '{8'hF0, 8'hF0, 8'hAA, 8'd3, 8'h7F, 8'hFF, 8'd10, 8'hFF};
  logic [7:0] vb  [8] = '{8'h3C, 8'h0F, 8'hFF, 8'd5, 8'h01, 8'h01, 8'd3, 8'h00};
  logic [2:0] vop [8] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2};
  logic [8:0] xres[8] = '{9'h030, 9'h0FF, 9'h055, 9'h1FE, 9'h080, 9'h100, 9'h007, 9'h000};
  logic       xovf[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.cmd_op    = 3'd0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", cmd_count, 0);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_alu_op", bus.alu_op, 3'b111);
    tick();

    // Single add: two cycles from accept to response
    bus.rsp_ready = 1'b1;
    n0 = log_q.size();
    send(8'd200, 8'd100, 3'd0, 4'd3);
    @(negedge clk);
    check("add_issue_a", bus.alu_a, 200);
    check("add_rsp_early1", bus.rsp_valid, 0);
    @(negedge clk);
    check("add_rsp_early2", bus.rsp_valid, 0);
    @(negedge clk);
    check("add_rsp_valid", bus.rsp_valid, 1);
    check("add_result", bus.rsp_result, 9'h12C);
    check("add_overflow", bus.rsp_overflow, 0);
    check("add_tag", bus.rsp_tag, 3);
    check("add_illegal", bus.rsp_illegal, 0);
    drain(20);
    check("add_log_n", log_q.size() - n0, 1);

    // Back-to-back: eight responses on consecutive cycles in tag order
    n0 = log_q.size();
    for (int k = 0; k < 8; k++) send(va[k], vb[k], vop[k], TAG_W'(k));
    drain(40);
    check("b2b_n", log_q.size() - n0, 8);
    if (log_q.size() - n0 == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("b2b_tag", log_q[n0+k].tag, k);
        check("b2b_res", log_q[n0+k].res, xres[k]);
        check("b2b_ovf", log_q[n0+k].ovf, xovf[k]);
        if (k > 0) check("b2b_gap", log_cyc[n0+k] - log_cyc[n0+k-1], 1);
      end
    end

    // Backpressure: two responses held, FIFO full after six accepts
    bus.rsp_ready = 1'b0;
    n0 = log_q.size();
    for (int k = 0; k < 6; k++) send(8'(k + 1), 8'd2, 3'd0, TAG_W'(k + 8));
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'd7;
    bus.cmd_b     = 8'd2;
    bus.cmd_op    = 3'd0;
    bus.cmd_tag   = 4'd14;
    repeat (4) begin
      @(negedge clk);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_count", cmd_count, DEPTH);
      check("bp_alu_idle", bus.alu_op, 3'b111);
      check("bp_head_tag", bus.rsp_tag, 8);
    end
    check("bp_no_rsp", log_q.size() - n0, 0);
    tick();
    bus.rsp_ready = 1'b1;
    send(8'd7, 8'd2, 3'd0, 4'd14);
    send(8'd8, 8'd2, 3'd0, 4'd15);
    send(8'd9, 8'd2, 3'd0, 4'd0);
    send(8'd10, 8'd2, 3'd0, 4'd1);
    drain(60);
    check("bp_n", log_q.size() - n0, 10);
    if (log_q.size() - n0 == 10) begin
      for (int k = 0; k < 10; k++) begin
        check("bp_tag", log_q[n0+k].tag, (k + 8) % 16);
        check("bp_res", log_q[n0+k].res, k + 3);
      end
    end

    // Illegal op and a legal neighbour
    n0 = log_q.size();
    send(8'd5, 8'd7, 3'b110, 4'd9);
    send(8'd5, 8'd7, 3'd0, 4'd10);
    drain(20);
    check("ill_n", log_q.size() - n0, 2);
    if (log_q.size() - n0 == 2) begin
      check("ill_fields", {log_q[n0].res, log_q[n0].ovf, log_q[n0].tag, log_q[n0].ill},
            {9'd0, 1'b0, 4'd9, 1'b1});
      check("legal_fields", {log_q[n0+1].res, log_q[n0+1].ovf, log_q[n0+1].tag,
            log_q[n0+1].ill}, {9'd12, 1'b0, 4'd10, 1'b0});
    end

    // Reset mid-flight: one command in flight, three queued, one response pending
    bus.rsp_ready = 1'b0;
    n0 = log_q.size();
    for (int k = 0; k < 6; k++) send(8'(k + 20), 8'd1, 3'd3, TAG_W'(k));
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", cmd_count, 0);
    check("mid_rst_rsp_after", bus.rsp_valid, 0);
    repeat (5) tick();
    check("mid_rst_n", log_q.size() - n0, 1);
    send(8'd50, 8'd3, 3'd1, 4'd11);
    drain(20);
    check("post_rst_n", log_q.size() - n0, 2);
    if (log_q.size() - n0 == 2) begin
      check("mid_rst_first_tag", log_q[n0].tag, 0);
      check("post_rst_fields", {log_q[n0+1].res, log_q[n0+1].ovf, log_q[n0+1].tag},
            {9'h02F, 1'b0, 4'd11});
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
